// File: rtl/bumpy_collision_detector.sv
// bumpy_collision_detector
//
// Per-frame collision detector for the Bumpy game. It watches the brick-wall
// drawing request together with the ball drawing request and the ball's
// in-sprite offsets, pixel by pixel. Across each VGA frame it accumulates:
//   - the overlap pixel count (saturating),
//   - the OR of the edge bands that were hit, and
//   - the position of the first overlapping pixel.
// At every start of frame it publishes one collision report.
//
// Parameters:
//   BALL_WIDTH, BALL_HEIGHT  ball sprite size in pixels
//   EDGE_MARGIN              depth of each edge band used for direction
//   MIN_OVERLAP              overlap pixels needed before a collision is reported
//   COUNT_WIDTH              width of the saturating overlap counter
//
// Ports:
//   clk, resetN              clock; synchronous active-low reset
//   startOfFrame             one-cycle pulse on the first pixel of a frame
//   pixelX, pixelY           current pixel position
//   brick_drawingRequest     wall pixel present (already aligned with the ball)
//   ball_drawingRequest      ball pixel present
//   ballOffsetX/Y            pixel offset inside the ball sprite
//   collision                one-cycle report pulse (count >= MIN_OVERLAP)
//   collision_dir            {top, bottom, left, right} bands of reported frame
//   overlap_count            overlap pixels in the reported frame
//   hitPixelX/Y              first overlap position in the reported frame
module bumpy_collision_detector #(
  parameter int BALL_WIDTH  = 32,
  parameter int BALL_HEIGHT = 32,
  parameter int EDGE_MARGIN = 4,
  parameter int MIN_OVERLAP = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [10:0]            pixelX,
  input  logic [10:0]            pixelY,
  input  logic                   brick_drawingRequest,
  input  logic                   ball_drawingRequest,
  input  logic [10:0]            ballOffsetX,
  input  logic [10:0]            ballOffsetY,
  output logic                   collision,
  output logic [3:0]             collision_dir,
  output logic [COUNT_WIDTH-1:0] overlap_count,
  output logic [10:0]            hitPixelX,
  output logic [10:0]            hitPixelY
);

  localparam logic [10:0] LOW_EDGE    = 11'(EDGE_MARGIN);
  localparam logic [10:0] BOTTOM_EDGE = 11'(BALL_HEIGHT - EDGE_MARGIN);
  localparam logic [10:0] RIGHT_EDGE  = 11'(BALL_WIDTH - EDGE_MARGIN);
  localparam logic [COUNT_WIDTH-1:0] MIN_CNT = COUNT_WIDTH'(MIN_OVERLAP);

  typedef enum logic [1:0] {
    WAIT_SOF,
    ACCUM,
    REPORT
  } state_t;

  state_t state, next_state;

  logic                   overlap;
  logic [3:0]             pix_dir;
  logic                   latch;

  logic [COUNT_WIDTH-1:0] acc_count;
  logic [3:0]             acc_dir;
  logic                   acc_first;
  logic [10:0]            acc_hit_x;
  logic [10:0]            acc_hit_y;

  assign overlap = brick_drawingRequest && ball_drawingRequest;

  // Edge bands of the current pixel; a corner pixel sets two bits.
  assign pix_dir = {ballOffsetY < LOW_EDGE,
                    ballOffsetY >= BOTTOM_EDGE,
                    ballOffsetX < LOW_EDGE,
                    ballOffsetX >= RIGHT_EDGE};

  // A report is latched only when a full frame has been observed.
  assign latch = startOfFrame && (state != WAIT_SOF);

  always_comb begin
    next_state = state;
    case (state)
      WAIT_SOF: if (startOfFrame) next_state = ACCUM;
      ACCUM:    if (startOfFrame) next_state = REPORT;
      REPORT:   next_state = startOfFrame ? REPORT : ACCUM;
      default:  next_state = WAIT_SOF;
    endcase
  end

  // The pulse is derived from the latched count, so it tracks exactly the
  // cycle after each latch and needs no extra pulse register.
  always_comb begin
    collision = (state == REPORT) && (overlap_count >= MIN_CNT);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state         <= WAIT_SOF;
      acc_count     <= '0;
      acc_dir       <= '0;
      acc_first     <= 1'b0;
      acc_hit_x     <= '0;
      acc_hit_y     <= '0;
      collision_dir <= '0;
      overlap_count <= '0;
      hitPixelX     <= '0;
      hitPixelY     <= '0;
    end else begin
      state <= next_state;

      // On SOF the accumulators restart with this pixel as the first pixel
      // of the new frame, so an overlap here never leaks into the report.
      if (startOfFrame) begin
        acc_count <= overlap ? COUNT_WIDTH'(1) : '0;
        acc_dir   <= overlap ? pix_dir : '0;
        acc_first <= overlap;
        acc_hit_x <= overlap ? pixelX : '0;
        acc_hit_y <= overlap ? pixelY : '0;
      end else if (overlap && (state != WAIT_SOF)) begin
        if (acc_count != '1) begin
          acc_count <= acc_count + COUNT_WIDTH'(1);
        end
        acc_dir <= acc_dir | pix_dir;
        if (!acc_first) begin
          acc_first <= 1'b1;
          acc_hit_x <= pixelX;
          acc_hit_y <= pixelY;
        end
      end

      if (latch) begin
        overlap_count <= acc_count;
        collision_dir <= (acc_count >= MIN_CNT) ? acc_dir : '0;
        hitPixelX     <= acc_hit_x;
        hitPixelY     <= acc_hit_y;
      end
    end
  end

endmodule

// File: tb/tb_bumpy_collision_detector.sv
module tb_bumpy_collision_detector;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic        brick_drawingRequest, ball_drawingRequest;
  logic [10:0] ballOffsetX, ballOffsetY;

  logic        collision;
  logic [3:0]  collision_dir;
  logic [15:0] overlap_count;
  logic [10:0] hitPixelX, hitPixelY;

  logic        collision4;
  logic [3:0]  collision_dir4;
  logic [3:0]  overlap_count4;
  logic [10:0] hitPixelX4, hitPixelY4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bumpy_collision_detector #(
    .BALL_WIDTH (32),
    .BALL_HEIGHT(32),
    .EDGE_MARGIN(4),
    .MIN_OVERLAP(3),
    .COUNT_WIDTH(16)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .pixelX              (pixelX),
    .pixelY              (pixelY),
    .brick_drawingRequest(brick_drawingRequest),
    .ball_drawingRequest (ball_drawingRequest),
    .ballOffsetX         (ballOffsetX),
    .ballOffsetY         (ballOffsetY),
    .collision           (collision),
    .collision_dir       (collision_dir),
    .overlap_count       (overlap_count),
    .hitPixelX           (hitPixelX),
    .hitPixelY           (hitPixelY)
  );

  bumpy_collision_detector #(
    .BALL_WIDTH (32),
    .BALL_HEIGHT(32),
    .EDGE_MARGIN(4),
    .MIN_OVERLAP(3),
    .COUNT_WIDTH(4)
  ) dut4 (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .pixelX              (pixelX),
    .pixelY              (pixelY),
    .brick_drawingRequest(brick_drawingRequest),
    .ball_drawingRequest (ball_drawingRequest),
    .ballOffsetX         (ballOffsetX),
    .ballOffsetY         (ballOffsetY),
    .collision           (collision4),
    .collision_dir       (collision_dir4),
    .overlap_count       (overlap_count4),
    .hitPixelX           (hitPixelX4),
    .hitPixelY           (hitPixelY4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel: drive, take the edge, settle 1 time unit past it.
  task automatic pix(input logic s, input logic br, input logic bl,
                     input int x, input int y, input int ox, input int oy);
    startOfFrame         = s;
    brick_drawingRequest = br;
    ball_drawingRequest  = bl;
    pixelX               = 11'(x);
    pixelY               = 11'(y);
    ballOffsetX          = 11'(ox);
    ballOffsetY          = 11'(oy);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_report(input string tag, input logic c, input logic [3:0] d,
                            input logic [15:0] n, input int hx, input int hy);
    chk({tag, "_coll"}, 32'(collision), 32'(c));
    chk({tag, "_dir"},  32'(collision_dir), 32'(d));
    chk({tag, "_cnt"},  32'(overlap_count), 32'(n));
    chk({tag, "_hx"},   32'(hitPixelX), 32'(hx));
    chk({tag, "_hy"},   32'(hitPixelY), 32'(hy));
  endtask

  initial begin
    resetN = 1'b0;
    pix(0, 0, 0, 0, 0, 0, 0);
    pix(0, 1, 1, 1, 1, 0, 0);
    chk_report("reset", 1'b0, 4'h0, 16'd0, 0, 0);
    chk("reset_coll4", 32'(collision4), 32'd0);
    resetN = 1'b1;

    // Overlaps before the first SOF are ignored; first SOF gives no report.
    for (int i = 0; i < 10; i++) pix(0, 1, 1, 100 + i, 50, 0, 0);
    pix(1, 0, 0, 0, 0, 0, 0);
    chk_report("first_sof", 1'b0, 4'h0, 16'd0, 0, 0);
    pix(0, 0, 0, 0, 0, 0, 0);
    chk("first_sof_after", 32'(collision), 32'd0);

    // Top hit: 5 overlaps, interleaved with ball-only pixels.
    for (int i = 0; i < 5; i++) begin
      pix(0, 1, 1, 200 + i, 150, 16, 1);
      pix(0, 0, 1, 300, 150, 16, 1);
    end
    pix(1, 0, 0, 0, 0, 0, 0);
    chk_report("top", 1'b1, 4'b1000, 16'd5, 200, 150);
    pix(0, 0, 0, 0, 0, 0, 0);
    chk("top_pulse_end", 32'(collision), 32'd0);
    chk("top_hold_cnt", 32'(overlap_count), 32'd5);

    // Below threshold: right band, count 2, direction forced to 0.
    pix(0, 1, 1, 300, 100, 30, 16);
    pix(0, 1, 1, 301, 100, 30, 16);
    pix(1, 0, 0, 0, 0, 0, 0);
    chk_report("below", 1'b0, 4'b0000, 16'd2, 300, 100);
    pix(0, 0, 0, 0, 0, 0, 0);
    chk("below_after", 32'(collision), 32'd0);

    // Corner (bottom-left) x3, then an overlap on the SOF cycle itself.
    for (int i = 0; i < 3; i++) pix(0, 1, 1, 10 + i, 20, 0, 31);
    pix(1, 1, 1, 50, 60, 16, 16);
    chk_report("corner", 1'b1, 4'b0110, 16'd3, 10, 20);
    pix(0, 0, 0, 0, 0, 0, 0);
    pix(0, 0, 0, 0, 0, 0, 0);
    pix(1, 0, 0, 0, 0, 0, 0);
    chk_report("sof_pixel", 1'b0, 4'b0000, 16'd1, 50, 60);

    // SOF in REPORT: empty frame latches zero count and zero hit position.
    pix(1, 0, 0, 0, 0, 0, 0);
    chk_report("empty", 1'b0, 4'b0000, 16'd0, 0, 0);

    // Saturation: 20 centre overlaps; 4-bit counter stops at 15.
    for (int i = 0; i < 20; i++) pix(0, 1, 1, 5 + i, 5, 16, 16);
    pix(1, 0, 0, 0, 0, 0, 0);
    chk_report("sat16", 1'b1, 4'b0000, 16'd20, 5, 5);
    chk("sat4_cnt", 32'(overlap_count4), 32'd15);
    chk("sat4_coll", 32'(collision4), 32'd1);
    pix(0, 0, 0, 0, 0, 0, 0);
    chk("sat4_pulse_end", 32'(collision4), 32'd0);

    // Reset mid-frame discards the frame; next full frame reports normally.
    for (int i = 0; i < 6; i++) pix(0, 1, 1, 400 + i, 300, 16, 0);
    resetN = 1'b0;
    pix(0, 0, 0, 0, 0, 0, 0);
    chk_report("midreset", 1'b0, 4'h0, 16'd0, 0, 0);
    resetN = 1'b1;
    pix(1, 0, 0, 0, 0, 0, 0);
    chk_report("midreset_sof", 1'b0, 4'h0, 16'd0, 0, 0);
    for (int i = 0; i < 3; i++) pix(0, 1, 1, 7 + i, 8, 16, 0);
    pix(1, 0, 0, 0, 0, 0, 0);
    chk_report("after_reset", 1'b1, 4'b1000, 16'd3, 7, 8);
    pix(0, 0, 0, 0, 0, 0, 0);
    chk("after_reset_end", 32'(collision), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
